branch_resolution_queue: RTL
============================

// Module: branch_resolution_queue
// PURPOSE
//   In-order queue of in-flight branch predictions between Fetch and Execute. Fetch pushes each
//   predicted control-flow instruction with its prediction; Execute resolves the oldest entry.
//   The block compares prediction against outcome and generates the predictor update stream
//   that trains BTB/local/global/selector tables. It also raises the mispredict redirect and
//   flushes younger entries.
// PARAMETERS
//   ADDR_WIDTH  32  PC/target width
//   DEPTH       8   queue entries; power of 2, >=2; TAG_W = $clog2(DEPTH)
//   CNT_WIDTH   32  width of saturating statistics counters
// PORTS
//   clk_i             in   1           clock
//   rst_ni            in   1           async reset, active low
//   flush_i           in   1           pipeline flush (exception/trap): discard all entries
//   alloc_valid_i     in   1           Fetch pushes a prediction
//   alloc_ready_o     out  1           queue can accept (= count != DEPTH)
//   alloc_pc_i        in   ADDR_WIDTH  PC of branch/jump
//   alloc_taken_i     in   1           predicted taken (already gated by BTB hit)
//   alloc_target_i    in   ADDR_WIDTH  predicted target
//   alloc_btb_hit_i   in   1           BTB hit at prediction time
//   alloc_tag_o       out  TAG_W       slot index allocated on this push (= write pointer)
//   res_valid_i       in   1           Execute resolves oldest entry
//   res_taken_i       in   1           actual direction
//   res_target_i      in   ADDR_WIDTH  actual target
//   upd_valid_o       out  1           predictor update valid (1-cycle pulse)
//   upd_pc_o          out  ADDR_WIDTH  branch PC
//   upd_taken_o       out  1           actual direction
//   upd_target_o      out  ADDR_WIDTH  actual target
//   upd_mispredict_o  out  1           prediction was wrong
//   redirect_valid_o  out  1           fetch redirect pulse
//   redirect_pc_o     out  ADDR_WIDTH  correct next PC
//   empty_o           out  1           count == 0
//   proto_err_o       out  1           sticky: resolve seen while empty
//   branch_cnt_o      out  CNT_WIDTH   resolved branches, saturating
//   mispred_cnt_o     out  CNT_WIDTH   mispredictions, saturating
// BEHAVIOUR
//   - Reset: all pointers/count 0; every output 0 except alloc_ready_o=1, empty_o=1.
//   - Storage: circular buffer; rd/wr pointers wrap modulo DEPTH; count 0..DEPTH.
//   - Push accepted iff alloc_valid_i && alloc_ready_o; ready depends only on count, never on
//     res_valid_i (full + resolve same cycle: push still refused).
//   - Resolve acts on head entry only. Resolve while empty: ignored, proto_err_o set (cleared
//     only by reset).
//   - Mispredict = (pred_taken != res_taken) || (res_taken && pred_target != res_target).
//   - Latency: every output set by a resolve is registered and valid the cycle after res_valid_i:
//     upd_*, counters, redirect_*.
//   - redirect_valid_o pulses only on mispredict. redirect_pc_o = res_taken ? res_target : pc+4,
//     computed modulo 2^ADDR_WIDTH.
//   - Correct resolve: pop head; count -= 1, or unchanged if a push is accepted the same cycle.
//   - Mispredicting resolve: pop head and discard all younger entries: wr_ptr <= rd_ptr+1,
//     count <= 0. A push accepted in the same cycle is discarded (younger than the branch).
//   - flush_i has priority: count <= 0, wr_ptr <= rd_ptr. Same-cycle resolve and push are
//     ignored: no update, no counter increment. Outputs already registered still emit.
//   - Counters increment by 1 per valid resolve (mispred_cnt_o only on mispredict) and hold at
//     all-ones.
//   - Async reset mid-operation: queue emptied; an update pending in the output register is
//     dropped.
// TESTING
//   1. Push pc=0x100,taken=1,tgt=0x200; resolve taken,0x200 -> next cycle upd_valid_o=1,
//      mispredict=0, no redirect, empty_o=1.
//   2. Push pc=0x100,taken=0; resolve taken,0x180 -> redirect_valid_o=1, redirect_pc_o=0x180,
//      mispred_cnt_o=1.
//   3. Push pc=0x100,taken=1,tgt=0x200; resolve not-taken -> redirect_pc_o=0x104.
//      Edge case pc=0xFFFFFFFC -> redirect_pc_o=0x0.
//   4. Push DEPTH entries -> alloc_ready_o=0. Push+resolve (correct) same cycle -> push refused,
//      count=DEPTH-1. Repeat until the pointers wrap.
//   5. Push 4 entries; mispredict on head with simultaneous push -> count=0, empty_o=1; next
//      push gets tag = old rd_ptr+1.
//   6. flush_i with res_valid_i on a non-empty queue -> no upd_valid_o, empty_o=1.
//      Resolve while empty -> proto_err_o=1, held until reset.

Source files
------------

// File: rtl/branch_resolution_queue.sv
// In-order queue of predicted branches between Fetch and Execute: resolves the head entry,
// emits predictor updates and mispredict redirects, and squashes younger entries on a miss.
module branch_resolution_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 32,
    localparam int TAG_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    // allocation from Fetch
    input  logic                  alloc_valid_i,
    output logic                  alloc_ready_o,
    input  logic [ADDR_WIDTH-1:0] alloc_pc_i,
    input  logic                  alloc_taken_i,
    input  logic [ADDR_WIDTH-1:0] alloc_target_i,
    input  logic                  alloc_btb_hit_i,
    output logic [TAG_W-1:0]      alloc_tag_o,
    // resolution from Execute
    input  logic                  res_valid_i,
    input  logic                  res_taken_i,
    input  logic [ADDR_WIDTH-1:0] res_target_i,
    // predictor update stream
    output logic                  upd_valid_o,
    output logic [ADDR_WIDTH-1:0] upd_pc_o,
    output logic                  upd_taken_o,
    output logic [ADDR_WIDTH-1:0] upd_target_o,
    output logic                  upd_mispredict_o,
    // fetch redirect
    output logic                  redirect_valid_o,
    output logic [ADDR_WIDTH-1:0] redirect_pc_o,
    // status
    output logic                  empty_o,
    output logic                  proto_err_o,
    output logic [CNT_WIDTH-1:0]  branch_cnt_o,
    output logic [CNT_WIDTH-1:0]  mispred_cnt_o
);

    localparam logic [TAG_W:0]     COUNT_FULL = (TAG_W + 1)'(DEPTH);
    localparam logic [TAG_W-1:0]   PTR_ONE    = TAG_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    // Prediction storage
    logic [ADDR_WIDTH-1:0] pc_mem     [DEPTH];
    logic [ADDR_WIDTH-1:0] target_mem [DEPTH];
    logic                  taken_mem  [DEPTH];

    logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAG_W:0]   count_q,  count_d;

    logic push_acc;
    logic res_fire;
    logic res_empty;
    logic mispredict;

    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_target;
    logic                  head_taken;
    logic [ADDR_WIDTH-1:0] fallthrough_pc;

    // The BTB hit flag is already folded into alloc_taken_i by Fetch.
    logic unused_btb_hit;
    assign unused_btb_hit = alloc_btb_hit_i;

    assign alloc_ready_o = (count_q != COUNT_FULL);
    assign empty_o       = (count_q == '0);
    assign alloc_tag_o   = wr_ptr_q;

    assign push_acc  = alloc_valid_i && alloc_ready_o && !flush_i;
    assign res_fire  = res_valid_i && !empty_o && !flush_i;
    assign res_empty = res_valid_i && empty_o && !flush_i;

    assign head_pc        = pc_mem[rd_ptr_q];
    assign head_target    = target_mem[rd_ptr_q];
    assign head_taken     = taken_mem[rd_ptr_q];
    assign fallthrough_pc = head_pc + ADDR_WIDTH'(4);

    assign mispredict = (head_taken != res_taken_i) ||
                        (res_taken_i && (head_target != res_target_i));

    // Pointer/occupancy next state; flush dominates, then a mispredict squashes everything younger.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
        end else if (res_fire && mispredict) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            wr_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = '0;
        end else if (res_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                count_d = count_q - 1'b1;
            end
        end else if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments in every clocked block so all state updates see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the payload array has no reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            pc_mem[wr_ptr_q]     <= alloc_pc_i;
            target_mem[wr_ptr_q] <= alloc_target_i;
            taken_mem[wr_ptr_q]  <= alloc_taken_i;
        end
    end

    // Registered update and redirect; valids are single-cycle pulses, payloads hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_valid_o      <= 1'b0;
            upd_pc_o         <= '0;
            upd_taken_o      <= 1'b0;
            upd_target_o     <= '0;
            upd_mispredict_o <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            upd_valid_o      <= res_fire;
            redirect_valid_o <= res_fire && mispredict;
            if (res_fire) begin
                upd_pc_o         <= head_pc;
                upd_taken_o      <= res_taken_i;
                upd_target_o     <= res_target_i;
                upd_mispredict_o <= mispredict;
                redirect_pc_o    <= res_taken_i ? res_target_i : fallthrough_pc;
            end
        end
    end

    // Saturating statistics and the sticky protocol error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
            proto_err_o   <= 1'b0;
        end else begin
            if (res_fire && (branch_cnt_o != CNT_MAX)) begin
                branch_cnt_o <= branch_cnt_o + 1'b1;
            end
            if (res_fire && mispredict && (mispred_cnt_o != CNT_MAX)) begin
                mispred_cnt_o <= mispred_cnt_o + 1'b1;
            end
            if (res_empty) begin
                proto_err_o <= 1'b1;
            end
        end
    end

endmodule
